// File: rtl/sqrt_sched.sv
// Round-robin scheduler sharing one sqrt engine between two requesters.
// Optional engine watchdog enabled by defining SQRT_SCHED_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a request; grants one combinationally
// ISSUE     | one-cycle start pulse to the engine
// WAIT_ACK  | waiting for the engine to report busy
// WAIT_DONE | waiting for the engine to return to idle
// RESP      | one-cycle result strobe to the owner
module sqrt_sched #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  req_valid_i,
   input  logic [15:0] req_x_i,
   output logic [1:0]  req_ready_o,
   output logic [1:0]  resp_valid_o,
   output logic [3:0]  resp_y_o,
   output logic        resp_err_o,
   output logic        eng_start_o,
   output logic [7:0]  eng_x_o,
   input  logic [1:0]  eng_busy_i,
   input  logic [3:0]  eng_y_i
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;

   state_t      state_q;
   logic        last_q;
   logic        owner_q;
   logic [7:0]  x_q;
   logic [3:0]  y_q;
   logic [1:0]  resp_valid_q;
   logic        err_q;
   logic        start_q;
   logic [1:0]  gnt_d;
   logic        wd_hit;
   logic        unused_cfg;

   assign unused_cfg = |TIMEOUT_CYC;

   always_comb begin
      gnt_d = 2'b00;
      if (state_q == IDLE && !rst_i) begin
         case (req_valid_i)
            2'b01:   gnt_d = 2'b01;
            2'b10:   gnt_d = 2'b10;
            2'b11:   gnt_d = last_q ? 2'b01 : 2'b10;
            default: gnt_d = 2'b00;
         endcase
      end
   end

`ifdef SQRT_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         wd_q <= '0;
      else if (state_q == ISSUE)
         wd_q <= '0;
      else if (state_q == WAIT_ACK || state_q == WAIT_DONE)
         wd_q <= wd_q + 1'b1;
   end

   assign wd_hit = (state_q == WAIT_ACK || state_q == WAIT_DONE) &&
                   (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign resp_err_o = err_q;
`else
   assign wd_hit     = 1'b0;
   assign resp_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         owner_q      <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         resp_valid_q <= '0;
         err_q        <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         start_q      <= 1'b0;
         resp_valid_q <= '0;
         err_q        <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_d != 2'b00) begin
                  owner_q <= gnt_d[1];
                  last_q  <= gnt_d[1];
                  x_q     <= gnt_d[1] ? req_x_i[15:8] : req_x_i[7:0];
                  start_q <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: state_q <= WAIT_ACK;
            WAIT_ACK, WAIT_DONE: begin
               // Watchdog abort takes priority over a completion in the same cycle.
               if (wd_hit) begin
                  y_q          <= '0;
                  err_q        <= 1'b1;
                  resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                  state_q      <= RESP;
               end else if (state_q == WAIT_ACK) begin
                  if (eng_busy_i != 2'b00)
                     state_q <= WAIT_DONE;
               end else if (eng_busy_i == 2'b00) begin
                  y_q          <= eng_y_i;
                  resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                  state_q      <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = gnt_d;
   assign resp_valid_o = resp_valid_q;
   assign resp_y_o     = y_q;
   assign eng_start_o  = start_q;
   assign eng_x_o      = x_q;

endmodule
